// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 settings: register numbers, exception codes, PRId and register packing.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0]  REG_SR     = 5'd12;
    localparam logic [4:0]  REG_CAUSE  = 5'd13;
    localparam logic [4:0]  REG_EPC    = 5'd14;
    localparam logic [4:0]  REG_PRID   = 5'd15;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_INT    = 5'd0;
    localparam logic [4:0]  EXC_RI     = 5'd10;

    localparam logic [31:0] PRID_VALUE = 32'h0000_0290;

    // EXL is the only piece of control state; naming it makes the handler mode explicit.
    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } exl_state_t;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl, input logic ie);
        return {16'b0, im, 8'b0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc_code);
        return {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline-to-CP0 bus: M-stage exception info, interrupts, mtc0/mfc0 access and results.
interface cp0_exc_ctrl_if;

    logic [4:0]  ExcCodeIn;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [5:0]  HWInt;
    logic        EretM;
    logic        WE;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Req;

    modport master (
        output ExcCodeIn, PC_M, BD_M, HWInt, EretM, WE, A1, A2, DIn,
        input  DOut, EPCOut, Req
    );

    modport slave (
        input  ExcCodeIn, PC_M, BD_M, HWInt, EretM, WE, A1, A2, DIn,
        output DOut, EPCOut, Req
    );

endinterface

// File: rtl/cp0_exc_pri.sv
// Request and priority logic: decides whether an interrupt or exception is taken
// and which ExcCode gets recorded.
module cp0_exc_pri
    import cp0_exc_ctrl_pkg::*;
(
    input  logic [5:0] hwint,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exc_code_in,
    output logic       int_req,
    output logic       exc_req,
    output logic       req,
    output logic [4:0] sel_code
);

    // Interrupts outrank a synchronous exception arriving in the same cycle.
    always_comb begin
        int_req  = (|(hwint & im)) & ie & ~exl;
        exc_req  = (exc_code_in != EXC_NONE) & ~exl;
        req      = int_req | exc_req;
        sel_code = int_req ? EXC_INT : exc_code_in;
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId registers, exception entry,
// eret return and mtc0/mfc0 access.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    cp0_exc_ctrl_if.slave    bus
);

    exl_state_t  state;
    logic [5:0]  sr_im;
    logic        sr_ie;
    logic        sr_exl;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [4:0]  sel_code;
    logic [31:0] victim_pc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic [31:0] dout;

    assign sr_exl = (state == ST_HANDLER);

    cp0_exc_pri u_pri (
        .hwint       (bus.HWInt),
        .im          (sr_im),
        .ie          (sr_ie),
        .exl         (sr_exl),
        .exc_code_in (bus.ExcCodeIn),
        .int_req     (int_req),
        .exc_req     (exc_req),
        .req         (req),
        .sel_code    (sel_code)
    );

    // A delay-slot victim restarts at its branch, one word earlier (wraps at zero).
    assign victim_pc = bus.BD_M ? (bus.PC_M - 32'd4) : bus.PC_M;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_NORMAL;
            sr_im     <= '0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= bus.HWInt;
            if (req) begin
                state     <= ST_HANDLER;
                cause_bd  <= bus.BD_M;
                cause_exc <= sel_code;
                epc       <= {victim_pc[31:2], 2'b00};
            end else begin
                // A same-cycle mtc0 to SR overrides the eret's EXL clear.
                if (bus.EretM) begin
                    state <= ST_NORMAL;
                end
                if (bus.WE && (bus.A2 == REG_SR)) begin
                    sr_im <= bus.DIn[15:10];
                    sr_ie <= bus.DIn[0];
                    state <= bus.DIn[1] ? ST_HANDLER : ST_NORMAL;
                end
                if (bus.WE && (bus.A2 == REG_EPC)) begin
                    epc <= {bus.DIn[31:2], 2'b00};
                end
            end
        end
    end

    assign sr_word    = pack_sr(sr_im, sr_exl, sr_ie);
    assign cause_word = pack_cause(cause_bd, cause_ip, cause_exc);

    always_comb begin
        dout = '0;
        case (bus.A1)
            REG_SR:    dout = sr_word;
            REG_CAUSE: dout = cause_word;
            REG_EPC:   dout = epc;
            REG_PRID:  dout = PRID_VALUE;
            default:   dout = '0;
        endcase
    end

    assign bus.DOut   = dout;
    assign bus.EPCOut = epc;
    assign bus.Req    = req;

    // Exception bookkeeping signals kept visible for debug of priority decisions.
    logic unused_reqs;
    assign unused_reqs = int_req ^ exc_req;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed self-checking bench for cp0_exc_ctrl: exception entry, priority,
// EXL masking, eret, mtc0 gating and asynchronous reset.
module tb_cp0_exc_ctrl;
    import cp0_exc_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    cp0_exc_ctrl_if bus();

    cp0_exc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkReg(input string tag, input logic [4:0] a, input logic [31:0] expected);
        bus.A1 = a;
        #1;
        checkOutput(tag, bus.DOut, expected);
    endtask

    task automatic applyStimulus(input logic [4:0] exc, input logic [31:0] pc, input logic bd,
                                 input logic [5:0] hw, input logic eret, input logic we,
                                 input logic [4:0] a2, input logic [31:0] din);
        bus.ExcCodeIn = exc;
        bus.PC_M      = pc;
        bus.BD_M      = bd;
        bus.HWInt     = hw;
        bus.EretM     = eret;
        bus.WE        = we;
        bus.A2        = a2;
        bus.DIn       = din;
        #1;
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b1;
        bus.A1      = 5'd0;
        applyStimulus(5'd0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 5'd0, 32'h0);
        #4;
        checkOutput("reset_req", {31'b0, bus.Req}, 32'h0);
        checkOutput("reset_epcout", bus.EPCOut, 32'h0);
        checkReg("reset_sr", REG_SR, 32'h0);
        checkReg("reset_cause", REG_CAUSE, 32'h0);
        checkReg("reset_prid", REG_PRID, 32'h0000_0290);
        @(negedge clk);
        reset = 1'b0;

        // mtc0 SR: IM[0] and IE enabled
        applyStimulus(5'd0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b1, REG_SR, 32'h0000_0401);
        checkOutput("mtc0_sr_no_req", {31'b0, bus.Req}, 32'h0);
        waitCycle();
        checkReg("sr_after_mtc0", REG_SR, 32'h0000_0401);

        // Interrupt on line 0 is taken in the same cycle
        applyStimulus(5'd0, 32'h0000_1000, 1'b0, 6'b000001, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("int_req_comb", {31'b0, bus.Req}, 32'h1);
        waitCycle();
        checkReg("int_sr_exl", REG_SR, 32'h0000_0403);
        checkReg("int_cause", REG_CAUSE, 32'h0000_0400);
        checkReg("int_epc", REG_EPC, 32'h0000_1000);
        checkOutput("int_epcout", bus.EPCOut, 32'h0000_1000);
        checkOutput("int_masked_by_exl", {31'b0, bus.Req}, 32'h0);

        // eret returns to NORMAL
        applyStimulus(5'd0, 32'h0000_1000, 1'b0, 6'd0, 1'b1, 1'b0, 5'd0, 32'h0);
        waitCycle();
        checkReg("eret1_sr", REG_SR, 32'h0000_0401);

        // RI in delay slot, with a simultaneous eret that must lose
        applyStimulus(EXC_RI, 32'h0000_3008, 1'b1, 6'd0, 1'b1, 1'b0, 5'd0, 32'h0);
        checkOutput("ri_req_comb", {31'b0, bus.Req}, 32'h1);
        waitCycle();
        checkReg("ri_sr_exl", REG_SR, 32'h0000_0403);
        checkReg("ri_cause", REG_CAUSE, 32'h8000_0028);
        checkReg("ri_epc", REG_EPC, 32'h0000_3004);

        // New exception while EXL=1 is suppressed
        applyStimulus(5'd4, 32'h0000_5000, 1'b0, 6'd0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("exl_suppress_req", {31'b0, bus.Req}, 32'h0);
        waitCycle();
        checkReg("exl_cause_kept", REG_CAUSE, 32'h8000_0028);
        checkReg("exl_epc_kept", REG_EPC, 32'h0000_3004);
        applyStimulus(5'd0, 32'h0000_5000, 1'b0, 6'd0, 1'b1, 1'b0, 5'd0, 32'h0);
        waitCycle();
        checkReg("eret2_sr", REG_SR, 32'h0000_0401);

        // Interrupt and exception together, plus a dropped mtc0 EPC
        applyStimulus(5'd12, 32'h0000_2000, 1'b0, 6'b000001, 1'b0, 1'b1, REG_EPC, 32'hDEAD_0000);
        checkOutput("prio_req_comb", {31'b0, bus.Req}, 32'h1);
        waitCycle();
        checkReg("prio_cause_int", REG_CAUSE, 32'h0000_0400);
        checkReg("prio_epc_no_write", REG_EPC, 32'h0000_2000);

        // mtc0 in handler: Cause ignored, EPC low bits forced, SR controls EXL
        applyStimulus(5'd0, 32'h0000_2000, 1'b0, 6'd0, 1'b0, 1'b1, REG_CAUSE, 32'hFFFF_FFFF);
        waitCycle();
        checkReg("mtc0_cause_ignored", REG_CAUSE, 32'h0000_0000);
        applyStimulus(5'd0, 32'h0000_2000, 1'b0, 6'd0, 1'b0, 1'b1, REG_EPC, 32'h1234_5677);
        waitCycle();
        checkReg("mtc0_epc", REG_EPC, 32'h1234_5674);
        checkOutput("mtc0_epcout", bus.EPCOut, 32'h1234_5674);
        applyStimulus(5'd0, 32'h0000_2000, 1'b0, 6'd0, 1'b0, 1'b1, REG_SR, 32'hFFFF_FFFF);
        waitCycle();
        checkReg("mtc0_sr_all", REG_SR, 32'h0000_FC03);
        applyStimulus(5'd0, 32'h0000_2000, 1'b0, 6'd0, 1'b0, 1'b1, REG_SR, 32'h0000_FC01);
        waitCycle();
        checkReg("mtc0_sr_clear_exl", REG_SR, 32'h0000_FC01);

        // Delay-slot victim at PC 0 wraps EPC
        applyStimulus(EXC_RI, 32'h0000_0000, 1'b1, 6'd0, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("wrap_req_comb", {31'b0, bus.Req}, 32'h1);
        waitCycle();
        checkReg("wrap_epc", REG_EPC, 32'hFFFF_FFFC);
        checkReg("wrap_sr", REG_SR, 32'h0000_FC03);
        applyStimulus(5'd0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0, 5'd0, 32'h0);

        // Asynchronous reset mid-cycle while in the handler
        #2;
        reset = 1'b1;
        #1;
        checkReg("areset_sr", REG_SR, 32'h0);
        checkReg("areset_cause", REG_CAUSE, 32'h0);
        checkReg("areset_epc", REG_EPC, 32'h0);
        checkOutput("areset_epcout", bus.EPCOut, 32'h0);
        checkReg("areset_prid", REG_PRID, 32'h0000_0290);
        checkReg("areset_other", 5'd3, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        waitCycle();
        checkReg("post_reset_sr", REG_SR, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
